nibble_serial_compare_ctrl: RTL
===============================

Name: nibble_serial_compare_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands through one shared 4-bit magnitude-compare slice, one nibble per clock, MSB nibble first.
- Terminates early at the first unequal nibble.
- Intended use: datapaths needing wide compares without a full-width comparator; the result is held until the next operation.
- Uses a start/busy/done handshake with registered result flags.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and ≥ 4. NIB = WIDTH/4 nibbles.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- start  input  1  request a compare; sampled only in IDLE.
- a  input  WIDTH  operand A, unsigned; sampled on the accepting edge only.
- b  input  WIDTH  operand B, unsigned; sampled on the accepting edge only.
- busy  output  1  high while in COMPARE.
- done  output  1  one-cycle pulse; result flags valid from this cycle.
- equal  output  1  a == b; registered, held.
- greater  output  1  a > b; registered, held.
- less  output  1  a < b; registered, held.

Behaviour:
- Reset state:
  - While rst is high: state = IDLE; busy, done, equal, greater and less = 0; operand registers and nibble index cleared.
  - Reset is asynchronous.
  - Reset mid-compare abandons the operation; no done pulse follows.
- States:
  - IDLE, COMPARE. No separate done state.
- IDLE:
  - start = 1 at an edge accepts the request:
    - latch a and b into internal shift registers;
    - index = NIB-1;
    - clear equal, greater and less to 0;
    - busy = 1 and state = COMPARE.
  - start = 0: hold all outputs. Results from the previous compare persist.
- COMPARE:
  - Each edge compares the current top nibble of A against the top nibble of B, using the 4-bit slice enabled only in this state.
  - Nibbles differ:
    - set greater or less accordingly;
    - done = 1, busy = 0;
    - state = IDLE.
  - Nibbles equal and index == 0:
    - equal = 1;
    - done = 1, busy = 0;
    - state = IDLE.
  - Nibbles equal and index > 0:
    - shift both registers left by 4;
    - index = index - 1;
    - remain in COMPARE.
- start while busy is ignored. It is not queued and not latched.
- a and b may change freely after acceptance without affecting the result.
- Latency:
  - Acceptance edge E0. If the first unequal nibble is nibble k (0 = MSB), the decision is registered at edge E(k+1).
  - done is high for the cycle after E(k+1), i.e. k+1 cycles after acceptance.
  - Full-equal case takes NIB cycles.
- done:
  - High for exactly one cycle.
  - Cleared on the next edge unless a new decision occurs. This cannot happen, because a new decision needs at least one COMPARE cycle.
- Back-to-back operation:
  - start high during the done cycle is accepted, because the state is already IDLE.
  - Flags clear on that edge, so the next operation begins with no bubble.
- Flag invariant:
  - At most one of equal, greater, less is high.
  - All three are 0 after reset and from acceptance until the decision.
- Width rules:
  - Index width is clog2(NIB), minimum 1.
  - Unsigned compare only.
  - Shift-in value is don't-care (zero).

Test Plan:
- WIDTH=16, a=0x1234, b=0x1234, start 1 cycle → busy high 4 cycles; done pulses 4 cycles after acceptance; equal=1, greater=0, less=0 held afterwards.
- a=0x9000, b=0x1FFF → decided at nibble 0; done 1 cycle after acceptance; greater=1; busy high exactly 1 cycle.
- a=0x12A4, b=0x12B4 → done 3 cycles after acceptance; less=1; changing a/b to 0xFFFF/0x0000 during busy does not alter the result.
- Start pulses on every cycle while busy → ignored; exactly one done per accepted start. Start during the done cycle is accepted: flags clear next edge, and a new result arrives with the correct latency.
- Assert rst asynchronously (off-edge) 2 cycles into a 4-nibble compare → all outputs 0 immediately; no done after release; next start behaves normally.
- Exhaustive 8-bit run (WIDTH=8, all 65536 a/b pairs) → flags match a reference compare; latency is 1 when the high nibbles differ, 2 otherwise.

Source files
------------

// File: rtl/nibble_serial_compare_ctrl.sv
// Wide unsigned magnitude compare done serially through one 4-bit slice,
// MSB nibble first, stopping at the first differing nibble.
module nibble_serial_compare_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             less
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;

    logic [3:0]         nib_a_c, nib_b_c;
    logic               slice_gt_c, slice_lt_c;

    // Shared 4-bit magnitude slice, only active while comparing
    always_comb begin
        nib_a_c    = a_q[WIDTH-1 -: 4];
        nib_b_c    = b_q[WIDTH-1 -: 4];
        slice_gt_c = 1'b0;
        slice_lt_c = 1'b0;
        if (state_q == COMPARE) begin
            slice_gt_c = (nib_a_c > nib_b_c);
            slice_lt_c = (nib_a_c < nib_b_c);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_W'(NIB - 1);
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (slice_gt_c || slice_lt_c) begin
                    gt_d    = slice_gt_c;
                    lt_d    = slice_lt_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    a_d   = a_q << 4;
                    b_d   = b_q << 4;
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign equal   = eq_q;
    assign greater = gt_q;
    assign less    = lt_q;

endmodule
